qspi_rom_responder: RTL and testbench
=====================================

# qspi_rom_responder

Cycle-accurate QSPI flash responder used as the far end of the CPU's QSPI ROM interface. It decodes the single-bit command set issued at CPU boot (FFh, ABh, 06h, 01h, EBh, plus 05h/35h), the quad fast-read with continuous-read mode, and streams bytes from a synchronous backing memory. It sits in the simulation and FPGA harness in place of the external flash, clocked from the same `clk` as the CPU core, with SCLK, CS and IO wired directly to it.

## Interface
- `ADDR_W`, 16: backing-memory address width. The 24-bit flash address is truncated to its low `ADDR_W` bits.
- `DUMMY_CLKS`, 4: dummy SCLK rising edges after the mode nibbles.
- `clk` in 1: system clock; the same clock as the master.
- `rst` in 1: reset, synchronous and active-high.
- `sclk` in 1: master SPI clock, a registered master output in the `clk` domain.
- `cs_n` in 1: chip select, active-low.
- `io_in` in 4: master-driven IO[3:0].
- `io_out` out 4: responder-driven IO[3:0].
- `io_oe` out 4: per-bit drive enable, 1 = responder drives.
- `rom_addr` out ADDR_W: backing-memory read address.
- `rom_rdata` in 8: memory data, valid one `clk` after `rom_addr`.
- `qe` out 1: SR2[1], quad enable.
- `wel` out 1: SR1[1], write enable latch.
- `cont_mode` out 1: continuous-read mode is armed.

## Operation
- **Edge detection**
  - `sclk_q` holds `sclk` delayed one `clk`.
  - A rise is `sclk & ~sclk_q` while `cs_n`=0.
  - Inputs are sampled only on a rise.
- **Output update**
  - Outputs change in the same `clk` in which a rise is detected.
  - The value presented is the one for the *next* rise. From the master this is equivalent to driving on the falling edge.
- **Chip select high**
  - State returns to IDLE.
  - `io_oe`=0.
  - Any partial byte is discarded.
  - `qe`, `wel` and `cont_mode` persist.
- **States:** IDLE, CMD, WSR, RDSR, ADDR, MODE, DUMMY, DATA, IGNORE.
- **IDLE → CMD or ADDR on the first rise after `cs_n` falls**
  - `cont_mode`=0: go to CMD (8 bits on `io_in[0]`, MSB first).
  - `cont_mode`=1: go to ADDR; the first rise already carries address nibble 5.
- **CMD decode after bit 8**
  - FFh: clear `cont_mode`, go to IGNORE.
  - ABh: no-op, go to IGNORE.
  - 06h: `wel`=1, go to IGNORE.
  - 01h: go to WSR.
  - 05h / 35h: go to RDSR for SR1 / SR2.
  - EBh: go to ADDR when `qe`=1, otherwise IGNORE.
  - Any other value: go to IGNORE.
- **WSR**
  - Shifts in up to 2 bytes: SR1, then SR2.
  - Commit happens on `cs_n` rising after at least 1 full byte, and only if `wel`=1.
  - SR1 takes byte 1 with `wel` forced to 0.
  - SR2 takes byte 2 if present.
  - `wel` is cleared on every 01h completion.
- **RDSR**
  - `io_oe`=4'b0010.
  - Outputs the status register MSB-first on `io_out[1]`, repeating until `cs_n` rises.
- **ADDR**
  - 6 nibbles, MSB first, into a 24-bit address.
  - On the 6th: `rom_addr` ← addr[ADDR_W-1:0]; go to MODE.
- **MODE**
  - 2 nibbles.
  - `cont_mode` ← (mode[5:4]==2'b10).
  - Then go to DUMMY.
- **DUMMY**
  - Counts `DUMMY_CLKS` rises.
  - On the last one: `io_oe`=4'hF and `io_out`=byte[7:4]; go to DATA.
- **DATA**
  - Each rise toggles the nibble phase.
  - After a high nibble is consumed, `io_out`=byte[3:0] and `rom_addr` increments, wrapping at 2^ADDR_W.
  - After a low nibble is consumed, the next fetched byte's high nibble is driven.
  - Streaming is unbounded.
- **Continuous-mode abort**
  - If `cont_mode`=1 and `cs_n` rises before MODE completes with every sampled nibble == Fh, clear `cont_mode`.
  - This is the FFh recovery path.
- **IGNORE:** no output until `cs_n` rises.

## Timing
- **Reset values**
  - `io_out`=0, `io_oe`=0, `rom_addr`=0.
  - `qe`=0, `wel`=0, `cont_mode`=0.
  - State IDLE.
- **Reset mid-transaction:** returns to the reset values immediately, even with `cs_n` low.
- **Minimum SCLK half-period:** 1 `clk`, matching the master.
- **Memory latency**
  - `rom_rdata` is registered into a byte buffer one `clk` after `rom_addr` changes.
  - Slack is ≥2 `clk` in DATA and ≥12 `clk` between address and first data.
- **Master-side read latency:** the first data nibble is valid before the rise that follows the last dummy rise.

## Structure
- **Shared package `qspi_pkg`:**
  - opcode constants: `OP_RSTCM`=FFh, `OP_RDP`=ABh, `OP_WREN`=06h, `OP_WRSR`=01h, `OP_RDSR1`=05h, `OP_RDSR2`=35h, `OP_QREAD`=EBh;
  - the state enum;
  - `MODE_CONT`=2'b10.
- **Sub-module:** one, `sclk_edge_detect`, producing the rise strobe.
- **Backing memory:** external to this block.

## Test plan
- **Boot sequence:** full CPU boot sequence (FFh, ABh, 06h, 01h 02h 02h, EBh + addr 000000h + mode A5h + 4 dummy + 2 nibbles) → `qe`=1, `wel`=0, `cont_mode`=1, first byte = mem[0].
- **Continuous read:** `cont_mode`=1, `cs_n` low, nibbles 0,0,0,1,2,3 then A,5 → `rom_addr`=0123h; 4 bytes streamed equal mem[0123h..0126h].
- **Wrap:** read at 00FFFFh with `ADDR_W`=16 streaming 2 bytes → mem[FFFFh] then mem[0000h].
- **Write-status guard:** 01h 00h 02h without a preceding 06h → `qe` stays 0; a following EBh goes to IGNORE with `io_oe` held at 0.
- **Read status:** 05h after 06h → `io_out[1]` serialises 02h with `io_oe`=0010b; 35h after boot → 02h.
- **Abort and reset:** continuous-mode FFh pattern (IO[3:0]=Fh, 8 clocks, then `cs_n` high) → `cont_mode`=0. Separately, `rst` pulsed during DATA → `io_oe`=0 on the next `clk`.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI flash responder: opcodes, FSM states and
// the mode-byte pattern that arms continuous read.
package qspi_pkg;

    localparam logic [7:0] OP_RSTCM = 8'hFF;
    localparam logic [7:0] OP_RDP   = 8'hAB;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRSR  = 8'h01;
    localparam logic [7:0] OP_RDSR1 = 8'h05;
    localparam logic [7:0] OP_RDSR2 = 8'h35;
    localparam logic [7:0] OP_QREAD = 8'hEB;

    localparam logic [1:0] MODE_CONT = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_WSR,
        ST_RDSR,
        ST_ADDR,
        ST_MODE,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/sclk_edge_detect.sv
// Detects a rising SCLK edge in the clk domain while the responder is selected.
module sclk_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs_n,
    output logic rise
);

    logic sclk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= 1'b0;
        end else begin
            sclk_q <= sclk;
        end
    end

    assign rise = sclk & ~sclk_q & ~cs_n;

endmodule

// File: rtl/qspi_rom_responder.sv
// Cycle-accurate QSPI flash model: boot command set, status registers and quad
// fast-read with continuous-read mode, streaming from a synchronous memory.
module qspi_rom_responder
    import qspi_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DUMMY_CLKS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_rdata,
    output logic              qe,
    output logic              wel,
    output logic              cont_mode
);

    logic              rise;
    state_t            state;
    logic [4:0]        cnt;
    logic [6:0]        shreg;
    logic [ADDR_W-1:0] addr_sr;
    logic [1:0]        mode_hi;
    logic [7:0]        sr1;
    logic [7:0]        sr2;
    logic [7:0]        wsr_b1;
    logic [7:0]        wsr_b2;
    logic [1:0]        wsr_bytes;
    logic              rdsr_sel;
    logic [2:0]        bit_idx;
    logic              hi_phase;
    logic              all_f;
    logic [3:0]        byte_lo;

    logic [7:0]        cmd_next;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        status_sel;

    sclk_edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .sclk (sclk),
        .cs_n (cs_n),
        .rise (rise)
    );

    // Shifting nibbles into an ADDR_W-wide register keeps only the low bits
    // of the 24-bit flash address once all six nibbles have arrived.
    assign cmd_next   = {shreg, io_in[0]};
    assign addr_next  = ADDR_W'({addr_sr, io_in});
    assign status_sel = rdsr_sel ? sr2 : sr1;

    assign wel = sr1[1];
    assign qe  = sr2[1];

    // Every output is presented for the master's next rise, so they are all
    // updated in the clk that detects the current rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            io_out    <= 4'h0;
            io_oe     <= 4'h0;
            rom_addr  <= '0;
            cont_mode <= 1'b0;
            cnt       <= '0;
            shreg     <= '0;
            addr_sr   <= '0;
            mode_hi   <= '0;
            sr1       <= 8'h00;
            sr2       <= 8'h00;
            wsr_b1    <= 8'h00;
            wsr_b2    <= 8'h00;
            wsr_bytes <= 2'd0;
            rdsr_sel  <= 1'b0;
            bit_idx   <= 3'd0;
            hi_phase  <= 1'b0;
            all_f     <= 1'b0;
            byte_lo   <= 4'h0;
        end else begin
            byte_lo <= rom_rdata[3:0];
            if (cs_n) begin
                if (state == ST_WSR) begin
                    if (wsr_bytes != 2'd0 && sr1[1]) begin
                        sr1 <= wsr_b1 & 8'hFD;
                        if (wsr_bytes == 2'd2) begin
                            sr2 <= wsr_b2;
                        end
                    end else begin
                        sr1[1] <= 1'b0;
                    end
                end
                if (cont_mode && all_f && (state == ST_ADDR || state == ST_MODE)) begin
                    cont_mode <= 1'b0;
                end
                state     <= ST_IDLE;
                io_oe     <= 4'h0;
                io_out    <= 4'h0;
                cnt       <= '0;
                wsr_bytes <= 2'd0;
            end else if (rise) begin
                case (state)
                    ST_IDLE: begin
                        if (cont_mode) begin
                            addr_sr <= addr_next;
                            all_f   <= (io_in == 4'hF);
                            cnt     <= 5'd1;
                            state   <= ST_ADDR;
                        end else begin
                            shreg <= cmd_next[6:0];
                            cnt   <= 5'd1;
                            state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        shreg <= cmd_next[6:0];
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cnt <= '0;
                            case (cmd_next)
                                OP_RSTCM: begin
                                    cont_mode <= 1'b0;
                                    state     <= ST_IGNORE;
                                end
                                OP_RDP: state <= ST_IGNORE;
                                OP_WREN: begin
                                    sr1[1] <= 1'b1;
                                    state  <= ST_IGNORE;
                                end
                                OP_WRSR: state <= ST_WSR;
                                OP_RDSR1: begin
                                    rdsr_sel <= 1'b0;
                                    bit_idx  <= 3'd6;
                                    io_oe    <= 4'b0010;
                                    io_out   <= {2'b00, sr1[7], 1'b0};
                                    state    <= ST_RDSR;
                                end
                                OP_RDSR2: begin
                                    rdsr_sel <= 1'b1;
                                    bit_idx  <= 3'd6;
                                    io_oe    <= 4'b0010;
                                    io_out   <= {2'b00, sr2[7], 1'b0};
                                    state    <= ST_RDSR;
                                end
                                OP_QREAD: state <= qe ? ST_ADDR : ST_IGNORE;
                                default:  state <= ST_IGNORE;
                            endcase
                        end
                    end
                    ST_WSR: begin
                        if (wsr_bytes != 2'd2) begin
                            shreg <= cmd_next[6:0];
                            cnt   <= cnt + 5'd1;
                            if (cnt[2:0] == 3'd7) begin
                                if (wsr_bytes == 2'd0) begin
                                    wsr_b1 <= cmd_next;
                                end else begin
                                    wsr_b2 <= cmd_next;
                                end
                                wsr_bytes <= wsr_bytes + 2'd1;
                            end
                        end
                    end
                    ST_RDSR: begin
                        io_out  <= {2'b00, status_sel[bit_idx], 1'b0};
                        bit_idx <= bit_idx - 3'd1;
                    end
                    ST_ADDR: begin
                        addr_sr <= addr_next;
                        if (io_in != 4'hF) begin
                            all_f <= 1'b0;
                        end
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd5) begin
                            rom_addr <= addr_next;
                            cnt      <= '0;
                            state    <= ST_MODE;
                        end
                    end
                    ST_MODE: begin
                        if (io_in != 4'hF) begin
                            all_f <= 1'b0;
                        end
                        if (cnt == 5'd0) begin
                            mode_hi <= io_in[1:0];
                            cnt     <= 5'd1;
                        end else begin
                            cont_mode <= (mode_hi == MODE_CONT);
                            cnt       <= '0;
                            state     <= ST_DUMMY;
                        end
                    end
                    ST_DUMMY: begin
                        if (cnt == 5'(DUMMY_CLKS - 1)) begin
                            io_oe    <= 4'hF;
                            io_out   <= rom_rdata[7:4];
                            hi_phase <= 1'b1;
                            cnt      <= '0;
                            state    <= ST_DATA;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    // The low nibble comes from the buffered byte because
                    // rom_addr moves on to the next byte in the same clk.
                    ST_DATA: begin
                        if (hi_phase) begin
                            io_out   <= byte_lo;
                            rom_addr <= rom_addr + ADDR_W'(1);
                            hi_phase <= 1'b0;
                        end else begin
                            io_out   <= rom_rdata[7:4];
                            hi_phase <= 1'b1;
                        end
                    end
                    ST_IGNORE: begin
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_rom_responder.sv
// Directed QSPI master sequence with random memory contents and addresses,
// checked against a status-register / memory-array reference model.
module tb_qspi_rom_responder;

    localparam int ADDR_W     = 16;
    localparam int DUMMY_CLKS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              sclk;
    logic              cs_n;
    logic [3:0]        io_in;
    logic [3:0]        io_out;
    logic [3:0]        io_oe;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_rdata;
    logic              qe;
    logic              wel;
    logic              cont_mode;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] got [$];

    logic [7:0] m_sr1;
    logic [7:0] m_sr2;
    logic       m_cont;

    int checks = 0;
    int errors = 0;

    qspi_rom_responder #(.ADDR_W(ADDR_W), .DUMMY_CLKS(DUMMY_CLKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oe     (io_oe),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .qe        (qe),
        .wel       (wel),
        .cont_mode (cont_mode)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_rdata <= mem[rom_addr];

    function automatic logic [7:0] exp_byte(input logic [23:0] a, input int i);
        return mem[ADDR_W'(a + 24'(i))];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SCLK period: data set up and sampled at the master's rise.
    task automatic spi_clk(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
        @(posedge clk); #1;
        io_in = d;
        sclk  = 1'b1;
        q     = io_out;
        oe    = io_oe;
        @(posedge clk); #1;
        sclk = 1'b0;
    endtask

    task automatic cs_begin();
        @(posedge clk); #1;
        cs_n = 1'b0;
    endtask

    task automatic cs_end();
        @(posedge clk); #1;
        cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] q, oe;
        for (int i = 7; i >= 0; i--) spi_clk({3'b000, b[i]}, q, oe);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        cs_begin();
        send_byte(b);
        cs_end();
    endtask

    task automatic quad_read(input logic [23:0] addr, input logic [7:0] mode, input int nbytes,
                             output logic [ADDR_W-1:0] addr_seen, output logic [3:0] first_oe);
        logic [3:0] q, oe, hi;
        got.delete();
        first_oe = 4'h0;
        cs_begin();
        if (!m_cont) send_byte(8'hEB);
        for (int i = 5; i >= 0; i--) spi_clk(addr[i*4 +: 4], q, oe);
        addr_seen = rom_addr;
        spi_clk(mode[7:4], q, oe);
        spi_clk(mode[3:0], q, oe);
        for (int i = 0; i < DUMMY_CLKS; i++) spi_clk(4'h0, q, oe);
        for (int b = 0; b < nbytes; b++) begin
            spi_clk(4'h0, hi, oe);
            if (b == 0) first_oe = oe;
            spi_clk(4'h0, q, oe);
            got.push_back({hi, q});
        end
        cs_end();
    endtask

    task automatic read_status(input logic [7:0] op, input int nbits,
                               output logic [15:0] val, output logic oe_ok);
        logic [3:0] q, oe;
        val   = 16'h0;
        oe_ok = 1'b1;
        cs_begin();
        send_byte(op);
        for (int i = 0; i < nbits; i++) begin
            spi_clk(4'h0, q, oe);
            val = {val[14:0], q[1]};
            if (oe !== 4'b0010) oe_ok = 1'b0;
        end
        cs_end();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] seen;
        logic [3:0]        foe, q, oe, oe_acc;
        logic [15:0]       sval;
        logic              sok;
        logic [23:0]       ra;
        logic [7:0]        rm;

        rst   = 1'b1;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        io_in = 4'h0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
        m_sr1  = 8'h00;
        m_sr2  = 8'h00;
        m_cont = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_io_out", io_out, 4'h0);
        check_output("reset_io_oe", io_oe, 4'h0);
        check_output("reset_rom_addr", rom_addr, '0);
        check_output("reset_qe", qe, 1'b0);
        check_output("reset_wel", wel, 1'b0);
        check_output("reset_cont", cont_mode, 1'b0);
        rst = 1'b0;

        // Boot sequence
        send_cmd(8'hFF);
        m_cont = 1'b0;
        send_cmd(8'hAB);
        send_cmd(8'h06);
        m_sr1[1] = 1'b1;
        check_output("boot_wren_wel", wel, m_sr1[1]);
        cs_begin();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h02);
        cs_end();
        if (m_sr1[1]) begin
            m_sr1 = 8'h02 & 8'hFD;
            m_sr2 = 8'h02;
        end
        m_sr1[1] = 1'b0;
        check_output("boot_qe", qe, m_sr2[1]);
        check_output("boot_wel", wel, m_sr1[1]);
        quad_read(24'h000000, 8'hA5, 1, seen, foe);
        m_cont = 1'b1;
        check_output("boot_byte0", got[0], exp_byte(24'h0, 0));
        check_output("boot_data_oe", foe, 4'hF);
        check_output("boot_cont", cont_mode, m_cont);

        // Continuous read, no command byte
        quad_read(24'h000123, 8'hA5, 4, seen, foe);
        check_output("cont_rom_addr", seen, 16'h0123);
        for (int i = 0; i < 4; i++)
            check_output($sformatf("cont_byte%0d", i), got[i], exp_byte(24'h000123, i));

        // Address wrap at 2^ADDR_W
        quad_read(24'h00FFFF, 8'hA5, 2, seen, foe);
        check_output("wrap_byte0", got[0], exp_byte(24'h00FFFF, 0));
        check_output("wrap_byte1", got[1], exp_byte(24'h00FFFF, 1));

        // Random addresses and mode bytes; last one re-arms continuous mode
        for (int r = 0; r < 3; r++) begin
            ra = 24'($urandom);
            rm = (r == 2) ? 8'hA5 : 8'($urandom);
            quad_read(ra, rm, 3, seen, foe);
            check_output($sformatf("rand%0d_addr", r), seen, ra[ADDR_W-1:0]);
            for (int i = 0; i < 3; i++)
                check_output($sformatf("rand%0d_byte%0d", r, i), got[i], exp_byte(ra, i));
            m_cont = (rm[5:4] == 2'b10);
            check_output($sformatf("rand%0d_cont", r), cont_mode, m_cont);
        end

        // Continuous-mode FFh recovery
        cs_begin();
        for (int i = 0; i < 8; i++) spi_clk(4'hF, q, oe);
        cs_end();
        m_cont = 1'b0;
        check_output("abort_cont", cont_mode, m_cont);

        // Status register reads
        send_cmd(8'h06);
        m_sr1[1] = 1'b1;
        read_status(8'h05, 16, sval, sok);
        check_output("rdsr1_value", sval, {m_sr1, m_sr1});
        check_output("rdsr1_oe", sok, 1'b1);
        read_status(8'h35, 8, sval, sok);
        check_output("rdsr2_value", sval[7:0], m_sr2);
        check_output("rdsr2_oe", sok, 1'b1);

        // Reset in the middle of DATA
        cs_begin();
        send_byte(8'hEB);
        for (int i = 0; i < 6; i++) spi_clk(4'h0, q, oe);
        spi_clk(4'h0, q, oe);
        spi_clk(4'h0, q, oe);
        for (int i = 0; i < DUMMY_CLKS; i++) spi_clk(4'h0, q, oe);
        spi_clk(4'h0, q, oe);
        check_output("predata_oe", io_oe, 4'hF);
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("rst_data_oe", io_oe, 4'h0);
        check_output("rst_data_addr", rom_addr, '0);
        check_output("rst_data_qe", qe, 1'b0);
        check_output("rst_data_wel", wel, 1'b0);
        rst  = 1'b0;
        cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_sr1  = 8'h00;
        m_sr2  = 8'h00;
        m_cont = 1'b0;

        // Write-status without WREN must not take effect
        cs_begin();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
        cs_end();
        m_sr1[1] = 1'b0;
        check_output("guard_qe", qe, m_sr2[1]);
        check_output("guard_wel", wel, m_sr1[1]);
        cs_begin();
        send_byte(8'hEB);
        oe_acc = 4'h0;
        for (int i = 0; i < 12; i++) begin
            spi_clk(4'($urandom), q, oe);
            oe_acc = oe_acc | oe;
        end
        cs_end();
        check_output("guard_eb_oe", oe_acc, 4'h0);
        check_output("guard_cont", cont_mode, m_cont);
        read_status(8'h35, 8, sval, sok);
        check_output("guard_sr2", sval[7:0], m_sr2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
